mesi_coherence_ctrl: RTL

- Clocked, multi-line MESI coherence controller for one private cache.
- Holds the MESI state of NUM_LINES lines and serves CPU read/write requests over a valid/ready handshake.
- Issues bus transactions on misses and on writes to shared lines; applies snooped bus traffic from other caches.
- Sits between the CPU-side cache pipeline and the shared snooping bus; successor to the combinational next-state table.

---
 rtl/mesi_coherence_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mesi_coherence_ctrl.sv
// MESI coherence controller for one private cache: tracks per-line state,
// serves CPU requests, issues bus transactions and applies snooped traffic.
module mesi_coherence_ctrl #(
  parameter int NUM_LINES    = 16,
  parameter int IDX_W        = 4,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req_valid,
  input  logic                   cpu_req_write,
  input  logic [IDX_W-1:0]       cpu_req_idx,
  output logic                   cpu_req_ready,
  output logic                   cpu_done,
  output logic                   cpu_hit,
  output logic                   cpu_err,
  output logic                   bus_req_valid,
  output logic [1:0]             bus_req_type,
  output logic [IDX_W-1:0]       bus_req_idx,
  input  logic                   bus_req_ready,
  input  logic                   bus_resp_valid,
  input  logic                   bus_resp_shared,
  input  logic                   snoop_valid,
  input  logic [1:0]             snoop_type,
  input  logic [IDX_W-1:0]       snoop_idx,
  output logic                   snoop_flush,
  output logic [2*NUM_LINES-1:0] line_state
);

  typedef enum logic [1:0] {IDLE, BUS_REQ, WAIT_RESP} state_t;

  localparam logic [1:0] ST_I   = 2'b00;
  localparam logic [1:0] ST_M   = 2'b01;
  localparam logic [1:0] ST_S   = 2'b10;
  localparam logic [1:0] ST_E   = 2'b11;
  localparam logic [1:0] BT_INV = 2'b00;
  localparam logic [1:0] BT_WM  = 2'b01;
  localparam logic [1:0] BT_RM  = 2'b10;
  localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);

  state_t                      r_state, w_nextState;
  logic [NUM_LINES-1:0][1:0]   r_lines, w_snoopLines, w_nextLines;
  logic [1:0]                  r_type, w_nextType;
  logic [IDX_W-1:0]            r_idx, w_nextIdx;
  logic [7:0]                  r_cnt, w_nextCnt;
  logic                        r_done, r_hit, r_err, r_flush;
  logic                        w_done, w_hit, w_err, w_flush;
  logic [1:0]                  w_cur;

  // Remote traffic is applied first; the CPU path sees the post-snoop array.
  always_comb begin
    w_snoopLines = r_lines;
    w_flush      = 1'b0;
    if (snoop_valid) begin
      case (snoop_type)
        BT_RM: begin
          if (r_lines[snoop_idx] == ST_M) begin
            w_snoopLines[snoop_idx] = ST_S;
            w_flush                 = 1'b1;
          end else if (r_lines[snoop_idx] == ST_E) begin
            w_snoopLines[snoop_idx] = ST_S;
          end
        end
        BT_WM: begin
          w_flush                 = (r_lines[snoop_idx] == ST_M);
          w_snoopLines[snoop_idx] = ST_I;
        end
        BT_INV:  w_snoopLines[snoop_idx] = ST_I;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextLines = w_snoopLines;
    w_nextType  = r_type;
    w_nextIdx   = r_idx;
    w_nextCnt   = r_cnt;
    w_done      = 1'b0;
    w_hit       = 1'b0;
    w_err       = 1'b0;
    w_cur       = w_snoopLines[cpu_req_idx];
    case (r_state)
      IDLE: begin
        if (cpu_req_valid) begin
          w_nextIdx = cpu_req_idx;
          if (!cpu_req_write) begin
            if (w_cur != ST_I) begin
              w_done = 1'b1;
              w_hit  = 1'b1;
            end else begin
              w_nextType  = BT_RM;
              w_nextState = BUS_REQ;
            end
          end else begin
            case (w_cur)
              ST_M: begin
                w_done = 1'b1;
                w_hit  = 1'b1;
              end
              ST_E: begin
                w_nextLines[cpu_req_idx] = ST_M;
                w_done = 1'b1;
                w_hit  = 1'b1;
              end
              ST_S: begin
                w_nextType  = BT_INV;
                w_nextState = BUS_REQ;
              end
              default: begin
                w_nextType  = BT_WM;
                w_nextState = BUS_REQ;
              end
            endcase
          end
        end
      end
      BUS_REQ: begin
        if (bus_req_ready) begin
          w_nextState = WAIT_RESP;
          w_nextCnt   = '0;
        end
      end
      WAIT_RESP: begin
        if (bus_resp_valid) begin
          w_nextState = IDLE;
          w_done      = 1'b1;
          w_nextLines[r_idx] = (r_type == BT_RM) ?
                               (bus_resp_shared ? ST_S : ST_E) : ST_M;
        end else if (r_cnt == TO_LAST) begin
          w_nextState = IDLE;
          w_done      = 1'b1;
          w_err       = 1'b1;
        end else begin
          w_nextCnt = r_cnt + 8'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
    // A pending upgrade whose S copy was snooped away now needs the full line.
    if ((r_state != IDLE) && (r_type == BT_INV) && (w_snoopLines[r_idx] == ST_I))
      w_nextType = BT_WM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lines <= '0;
      r_type  <= BT_INV;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_lines <= w_nextLines;
      r_type  <= w_nextType;
      r_idx   <= w_nextIdx;
      r_cnt   <= w_nextCnt;
      r_done  <= w_done;
      r_hit   <= w_hit;
      r_err   <= w_err;
      r_flush <= w_flush;
    end
  end

  assign cpu_req_ready = (r_state == IDLE);
  assign bus_req_valid = (r_state == BUS_REQ);
  assign bus_req_type  = bus_req_valid ? r_type : BT_INV;
  assign bus_req_idx   = bus_req_valid ? r_idx : '0;
  assign cpu_done      = r_done;
  assign cpu_hit       = r_hit;
  assign cpu_err       = r_err;
  assign snoop_flush   = r_flush;
  assign line_state    = r_lines;

endmodule
